// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared FSM encoding and round-robin pointer helper for the packet arbiter.
package axis_pkt_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry skid stage: output register plus one skid register; 1-cycle latency.
// o_full is registered; the producer must only present i_vld while o_full is low.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_full,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat,
  input  logic             i_rdy
);

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_dat;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_skid_vld <= 1'b0;
      r_skid_dat <= '0;
    end else if (!r_out_vld || i_rdy) begin
      // Output slot frees up: the skid entry is older, so it drains first.
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= r_skid_dat;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= i_vld;
        if (i_vld) begin
          r_out_dat <= i_dat;
        end
      end
    end else if (i_vld) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= i_dat;
    end
  end

  assign o_full = r_skid_vld;
  assign o_vld  = r_out_vld;
  assign o_dat  = r_out_dat;

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-locked round-robin merge of S_COUNT AXI-Stream sources; 1-cycle latency, one bubble per packet.
// Source tready comes only from registered state, never from m_axis_tready.
module axis_pkt_rr_arbiter
  import axis_pkt_rr_arbiter_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  output logic [S_COUNT-1:0]            s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_idx,
  output logic                          pkt_done
);

  localparam int BEAT_W = DATA_WIDTH + 1 + ID_WIDTH;

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [ID_WIDTH-1:0]     r_rr_ptr;
  logic [ID_WIDTH-1:0]     w_rr_nxt;
  logic [ID_WIDTH-1:0]     r_grant;
  logic [ID_WIDTH-1:0]     w_grant_nxt;
  logic [ID_WIDTH-1:0]     w_pick;
  logic                    w_found;
  logic                    w_sel_vld;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_dat;
  logic                    w_acc;
  logic                    w_skid_full;
  logic                    r_pkt_done;
  logic [BEAT_W-1:0]       w_skid_in;
  logic [BEAT_W-1:0]       w_skid_out;

  // Rotate-priority select: first pass covers indices at/after rr_ptr, second pass the wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (!w_found && s_axis_tvalid[i] && (ID_WIDTH'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_pick  = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < S_COUNT; i++) begin
      if (!w_found && s_axis_tvalid[i]) begin
        w_found = 1'b1;
        w_pick  = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_dat  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (r_grant == ID_WIDTH'(i)) begin
        w_sel_vld  = s_axis_tvalid[i];
        w_sel_last = s_axis_tlast[i];
        w_sel_dat  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_axis_tready[i] = (r_state == ST_LOCK) && (r_grant == ID_WIDTH'(i)) && !w_skid_full;
    end
  end

  assign w_acc = (r_state == ST_LOCK) && w_sel_vld && !w_skid_full;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_acc && w_sel_last) begin
          w_rr_nxt    = ID_WIDTH'(rr_next(int'(r_grant), S_COUNT));
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_grant    <= w_grant_nxt;
      r_pkt_done <= w_acc && w_sel_last;
    end
  end

  assign w_skid_in = {w_sel_dat, w_sel_last, r_grant};

  axis_skid_reg #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_vld   (w_acc),
    .i_dat   (w_skid_in),
    .o_full  (w_skid_full),
    .o_vld   (m_axis_tvalid),
    .o_dat   (w_skid_out),
    .i_rdy   (m_axis_tready)
  );

  assign m_axis_tdata = w_skid_out[BEAT_W-1 -: DATA_WIDTH];
  assign m_axis_tlast = w_skid_out[ID_WIDTH];
  assign m_axis_tid   = w_skid_out[ID_WIDTH-1:0];
  assign busy         = (r_state == ST_LOCK);
  assign grant_idx    = r_grant;
  assign pkt_done     = r_pkt_done;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: source queues feed beats, expected output order is hand-listed.
module tb_axis_pkt_rr_arbiter;

  localparam int S  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S-1:0]    s_axis_tvalid;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]    s_axis_tlast;
  logic [S-1:0]    s_axis_tready;
  logic            m_axis_tvalid;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            m_axis_tready;
  logic            busy;
  logic [IW-1:0]   grant_idx;
  logic            pkt_done;

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(
    .S_COUNT    (S),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .grant_idx     (grant_idx),
    .pkt_done      (pkt_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int occ    = 0;
  int cyc    = 0;
  logic [3:0]     rdy_pat = 4'b1111;
  logic [S-1:0]   hold    = '0;
  logic [DW:0]    src_q [S][$];
  logic [IW+DW:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [DW:0] b;
    for (int i = 0; i < S; i++) begin
      if (src_q[i].size() != 0 && !hold[i]) begin
        b = src_q[i][0];
        s_axis_tvalid[i]         = 1'b1;
        s_axis_tdata[i*DW +: DW] = b[DW-1:0];
        s_axis_tlast[i]          = b[DW];
      end else begin
        s_axis_tvalid[i]         = 1'b0;
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
    m_axis_tready = rdy_pat[cyc[1:0]];
  endtask

  task automatic push_pkt(input int src, input int nb, input logic [DW-1:0] base);
    logic lst;
    for (int b = 0; b < nb; b++) begin
      lst = (b == nb - 1);
      src_q[src].push_back({lst, base + DW'(b)});
      exp_q.push_back({IW'(src), lst, base + DW'(b)});
    end
  endtask

  // One clock: observe handshakes at the falling edge, advance sources just after the rising edge.
  task automatic step();
    logic [S-1:0]   sacc;
    logic [IW+DW:0] got;
    logic [IW+DW:0] e;
    @(negedge clk);
    sacc = s_axis_tvalid & s_axis_tready;
    check("tready_onehot", ($countones(s_axis_tready) <= 1), 1);
    if (pkt_done) n_done++;
    if (m_axis_tvalid && m_axis_tready) begin
      got = {m_axis_tid, m_axis_tlast, m_axis_tdata};
      check("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_tid_last_data", got, e);
      end
      occ--;
    end
    occ += $countones(sacc);
    check("skid_occupancy", (occ <= 2), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      if (sacc[i]) void'(src_q[i].pop_front());
    end
    cyc++;
    drive();
  endtask

  task automatic run_drain(input int bound);
    for (int n = 0; n < bound && exp_q.size() != 0; n++) step();
    check("drain_complete", exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic clear_stim();
    hold = '0;
    for (int i = 0; i < S; i++) src_q[i].delete();
    exp_q.delete();
    occ     = 0;
    cyc     = 0;
    rdy_pat = 4'b1111;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_stim();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    clear_stim();
    #12;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tid", m_axis_tid, 0);
    check("rst_grant_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: nothing requested for 10 cycles.
    for (int n = 0; n < 10; n++) begin
      step();
      check("idle_m_tvalid", m_axis_tvalid, 0);
      check("idle_s_tready", s_axis_tready, 0);
      check("idle_busy", busy, 0);
    end

    // Sources 0 and 2 each present a 3-beat packet at once.
    n_done = 0;
    push_pkt(0, 3, 64'h0A00);
    push_pkt(2, 3, 64'h0C00);
    drive();
    run_drain(60);
    check("t2_pkt_done_count", n_done, 2);
    check("t2_grant_idx", grant_idx, 2);
    check("t2_busy_after", busy, 0);

    // All four sources continuously valid with 1-beat packets, from a fresh reset.
    do_reset();
    n_done = 0;
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < S; j++)
        push_pkt(j, 1, 64'h3000 + 64'(j) * 64'h100 + 64'(p));
    drive();
    run_drain(200);
    check("t3_pkt_done_count", n_done, 12);

    // 8-beat packet under downstream ready pattern 1,0,0,1.
    n_done  = 0;
    cyc     = 0;
    rdy_pat = 4'b1001;
    push_pkt(0, 8, 64'h0);
    drive();
    run_drain(200);
    rdy_pat = 4'b1111;
    drive();
    check("t4_pkt_done_count", n_done, 1);

    // Source 1 stalls mid-packet while source 3 waits.
    push_pkt(1, 4, 64'h5100);
    push_pkt(3, 1, 64'h5300);
    drive();
    for (int n = 0; n < 50 && src_q[1].size() > 2; n++) step();
    check("t5_src1_two_left", src_q[1].size(), 2);
    hold[1] = 1'b1;
    drive();
    for (int n = 0; n < 5; n++) begin
      step();
      check("t5_src3_tready", s_axis_tready[3], 0);
      check("t5_busy", busy, 1);
      check("t5_grant_idx", grant_idx, 1);
    end
    hold[1] = 1'b0;
    drive();
    run_drain(60);

    // Move rr_ptr to 3, then reset in the middle of a stalled source-3 packet.
    push_pkt(2, 1, 64'h6200);
    drive();
    run_drain(40);
    push_pkt(3, 6, 64'h6300);
    rdy_pat = 4'b0000;
    drive();
    repeat (4) step();
    check("t6_busy_before", busy, 1);
    check("t6_m_tvalid_before", m_axis_tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_m_tvalid", m_axis_tvalid, 0);
    check("t6_async_s_tready", s_axis_tready, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_grant_idx", grant_idx, 0);
    check("t6_async_m_tdata", m_axis_tdata, 0);
    check("t6_async_m_tid", m_axis_tid, 0);
    clear_stim();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(1, 1, 64'h6101);
    push_pkt(3, 1, 64'h6301);
    drive();
    run_drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
